// File: rtl/seq_det_param.sv
// ---------------------------------------------------------------------------
// seq_det_param
//
// Serial pattern detector. It watches a serial bit stream and flags every
// place where the most recent N accepted bits equal a runtime-programmable
// pattern. The pattern MSB is the oldest bit and the LSB is the newest.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous, active-low reset
//   en         sample strobe; x is consumed only when en=1
//   x          serial data bit
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   pat_load   load pat_in into the pattern register (wins over en)
//   pat_in     new N-bit pattern
//   cnt_clr    synchronous clear of match_cnt (wins over an increment)
//   y          combinational (Mealy) match pulse
//   y_q        y delayed by one clock
//   match_cnt  saturating count of matches
//   cnt_sat    high while match_cnt is all-ones
// ---------------------------------------------------------------------------
module seq_det_param #(
    parameter int             N           = 4,
    parameter logic [N-1:0]   DEF_PATTERN = N'(4'b1101),
    parameter int             CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    // The fill counter only needs to reach N-1, so $clog2(N) bits suffice.
    localparam int             FW       = (N > 2) ? $clog2(N) : 1;
    localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);

    logic [N-1:0]     pattern_q, pattern_d;
    logic [N-2:0]     hist_q,    hist_d;
    logic [FW-1:0]    fill_q,    fill_d;
    logic [CNT_W-1:0] cnt_d;

    logic [N-1:0]     window;
    logic [N-2:0]     shiftIn;
    logic             accept;

    // History after shifting in x. With N=2 the history is a single bit, so
    // the shifted value is just x; the general slice would be empty there.
    if (N > 2) begin : gShiftWide
        assign shiftIn = {hist_q[N-3:0], x};
    end else begin : gShiftNarrow
        assign shiftIn = x;
    end

    // The candidate window is the N-1 remembered bits plus the bit arriving
    // now, which is what makes y a same-cycle (Mealy) response.
    assign window = {hist_q, x};
    assign accept = en & ~pat_load;

    // fill saturates at N-1, so "fill >= N-1" reduces to an equality test.
    // This guard is also what stops the all-zero reset history from matching
    // an all-zero pattern.
    assign y = accept & (fill_q == FILL_MAX) & (window == pattern_q);

    assign cnt_sat = &match_cnt;

    // Next-state for the pattern, history and fill. A pattern load discards
    // the coincident sample and restarts the fill. A non-overlapping match
    // also restarts the fill; the history keeps shifting regardless because
    // it is fully overwritten before fill reaches N-1 again.
    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        if (pat_load) begin
            pattern_d = pat_in;
            fill_d    = '0;
        end else if (en) begin
            hist_d = shiftIn;
            if (y && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Match counter next-state: clear beats increment, and the count sticks
    // at all-ones rather than wrapping.
    always_comb begin
        cnt_d = match_cnt;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (y && !cnt_sat) begin
            cnt_d = match_cnt + 1'b1;
        end
    end

    // State registers, all cleared (pattern reloaded) by the async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= DEF_PATTERN;
            hist_q    <= '0;
            fill_q    <= '0;
            y_q       <= 1'b0;
            match_cnt <= '0;
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            y_q       <= y;
            match_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_det_param.sv
// ---------------------------------------------------------------------------
// tb_seq_det_param
//
// Drives two copies of the detector (8-bit and 2-bit counters) with the same
// stimulus. Every driven cycle pushes the expected outputs from a window
// based reference model into a queue; a monitor on the falling edge pops
// and compares, independently of the stimulus process.
// ---------------------------------------------------------------------------
module tb_seq_det_param;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         x = 1'b0;
    logic         overlap = 1'b0;
    logic         pat_load = 1'b0;
    logic [N-1:0] pat_in = '0;
    logic         cnt_clr = 1'b0;

    logic         y, y_q, cnt_sat;
    logic [7:0]   match_cnt;
    logic         y2, y2_q, cnt_sat2;
    logic [1:0]   match_cnt2;

    typedef struct {
        logic       y;
        logic       yq;
        logic [7:0] cnt8;
        logic       sat8;
        logic [1:0] cnt2;
        logic       sat2;
    } expT;

    expT sbQ[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: the accepted bits that still count toward a
    // match (cleared on reset, pattern load and non-overlapping match).
    bit           histQ[$];
    logic [N-1:0] patM = 4'b1101;
    logic         yqM  = 1'b0;
    int           cnt8M = 0;
    int           cnt2M = 0;

    seq_det_param #(.N(N), .DEF_PATTERN(4'b1101), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y), .y_q(y_q), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_det_param #(.N(N), .DEF_PATTERN(4'b1101), .CNT_W(2)) dutSat (
        .clk(clk), .reset_n(reset_n), .en(en), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y2), .y_q(y2_q), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    always #5 clk = ~clk;

    // One comparison; a mismatch prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then record what
    // the model expects to see during this cycle and advance the model past
    // the coming edge.
    task automatic applyStimulus(input logic e, input logic xi, input logic ov,
                                 input logic pl, input logic [N-1:0] pi,
                                 input logic clr);
        logic yM;
        expT  r;
        int   v;
        @(posedge clk);
        #1;
        en = e; x = xi; overlap = ov; pat_load = pl; pat_in = pi; cnt_clr = clr;

        yM = 1'b0;
        if (e && !pl && histQ.size() >= N - 1) begin
            v = 0;
            for (int i = histQ.size() - (N - 1); i < histQ.size(); i++)
                v = v * 2 + int'(histQ[i]);
            v = v * 2 + int'(xi);
            yM = (v == int'(patM));
        end

        r.y    = yM;
        r.yq   = yqM;
        r.cnt8 = 8'(cnt8M);
        r.sat8 = (cnt8M == 255);
        r.cnt2 = 2'(cnt2M);
        r.sat2 = (cnt2M == 3);
        sbQ.push_back(r);

        if (pl) begin
            patM = pi;
            histQ.delete();
        end else if (e) begin
            if (yM && !ov) begin
                histQ.delete();
            end else begin
                histQ.push_back(xi);
                if (histQ.size() > N - 1) void'(histQ.pop_front());
            end
        end

        if (clr) begin
            cnt8M = 0;
            cnt2M = 0;
        end else if (yM) begin
            if (cnt8M < 255) cnt8M++;
            if (cnt2M < 3)   cnt2M++;
        end
        yqM = yM;
    endtask

    // Feed a sequence of bits with en=1 and no load or clear.
    task automatic sendBits(input logic [15:0] bits, input int len, input logic ov);
        for (int i = len - 1; i >= 0; i--)
            applyStimulus(1'b1, bits[i], ov, 1'b0, '0, 1'b0);
    endtask

    // Short reset pulse between edges; registered outputs must clear at once.
    task automatic resetPulse();
        expT r;
        @(posedge clk);
        #1;
        en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
        reset_n = 1'b0;
        #2;
        checkOutput("rst_async_yq",   8'(y_q),    8'd0);
        checkOutput("rst_async_cnt",  match_cnt,  8'd0);
        checkOutput("rst_async_cnt2", 8'(match_cnt2), 8'd0);
        #1;
        reset_n = 1'b1;
        histQ.delete();
        patM  = 4'b1101;
        yqM   = 1'b0;
        cnt8M = 0;
        cnt2M = 0;
        r.y = 1'b0; r.yq = 1'b0; r.cnt8 = 8'd0; r.sat8 = 1'b0;
        r.cnt2 = 2'd0; r.sat2 = 1'b0;
        sbQ.push_back(r);
    endtask

    // Monitor: compares every cycle that has a recorded expectation.
    initial begin
        expT r;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                r = sbQ.pop_front();
                checkOutput("y",         8'(y),          8'(r.y));
                checkOutput("y_q",       8'(y_q),        8'(r.yq));
                checkOutput("match_cnt", match_cnt,      r.cnt8);
                checkOutput("cnt_sat",   8'(cnt_sat),    8'(r.sat8));
                checkOutput("match_cnt2", 8'(match_cnt2), 8'(r.cnt2));
                checkOutput("cnt_sat2",  8'(cnt_sat2),   8'(r.sat2));
            end
        end
    end

    // Stimulus: directed scenarios first, then a randomized soak.
    initial begin
        #3;
        checkOutput("reset_y",     8'(y),       8'd0);
        checkOutput("reset_y_q",   8'(y_q),     8'd0);
        checkOutput("reset_cnt",   match_cnt,   8'd0);
        checkOutput("reset_sat",   8'(cnt_sat), 8'd0);
        #4;
        reset_n = 1'b1;

        $display("[TB] overlapping 1101 stream");
        sendBits(16'b1101101, 7, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("overlap_cnt", match_cnt, 8'd2);

        $display("[TB] non-overlapping 1101 stream");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b1);
        sendBits(16'b1101101, 7, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("nonoverlap_cnt", match_cnt, 8'd1);

        $display("[TB] bubble test");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b1101, 1'b1);
        sendBits(16'b11, 2, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        sendBits(16'b01, 2, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("bubble_cnt", match_cnt, 8'd1);

        $display("[TB] all-zero pattern load and guard");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1);
        sendBits(16'b0000000, 7, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("zero_pat_cnt", match_cnt, 8'd4);

        $display("[TB] counter saturation");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b1101, 1'b1);
        sendBits(16'b1101101101101, 13, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("sat_cnt2", 8'(match_cnt2), 8'd3);
        checkOutput("sat_flag2", 8'(cnt_sat2), 8'd1);
        checkOutput("sat_cnt8", match_cnt, 8'd4);
        sendBits(16'b10, 2, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("clr_cnt2", 8'(match_cnt2), 8'd0);
        checkOutput("clr_flag2", 8'(cnt_sat2), 8'd0);
        checkOutput("clr_cnt8", match_cnt, 8'd0);

        $display("[TB] reset mid-stream");
        sendBits(16'b1101, 4, 1'b1);
        sendBits(16'b110, 3, 1'b1);
        resetPulse();
        sendBits(16'b1, 1, 1'b1);
        sendBits(16'b1101, 4, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_cnt", match_cnt, 8'd1);

        $display("[TB] randomized soak");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 8), 1'($urandom),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 49) == 0), N'($urandom),
                          1'($urandom_range(0, 99) == 0));
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("sb_drain", 8'(sbQ.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
